// File: rtl/stage_if.sv
// rtl/stage_if.sv - Instruction fetch stage: PC, synchronous-read fetch and IF/ID register
// A one-entry skid buffer keeps the in-flight response alive across hazard stalls.
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        IFin_PCSrc,
  input  logic [31:0] IFin_Btarg_or_Jtarg,
  input  logic        IFin_Stall,
  output logic [31:0] IFout_Iaddr,
  output logic        IFout_Ireq,
  input  logic [31:0] IFin_Inst,
  output logic [31:0] IFout_Inst,
  output logic [31:0] IFout_PC,
  output logic [31:0] IFout_PCplus4,
  output logic        IFout_Valid
);

  logic [31:0] pc_q;
  logic        f2_valid;
  logic [31:0] f2_pc;
  logic        skid_valid;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;

  // Source for an IF/ID load: a buffered instruction always beats the live response.
  logic [31:0] load_inst;
  logic [31:0] load_pc;
  logic        load_en;

  assign IFout_Iaddr = pc_q;
  assign IFout_Ireq  = Rst_n & ~IFin_Stall & ~IFin_PCSrc;

  always_comb begin
    load_inst = IFin_Inst;
    load_pc   = f2_pc;
    load_en   = f2_valid;
    if (skid_valid) begin
      load_inst = skid_inst;
      load_pc   = skid_pc;
      load_en   = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc_q          <= RESET_PC;
      f2_valid      <= 1'b0;
      f2_pc         <= 32'h0;
      skid_valid    <= 1'b0;
      skid_inst     <= 32'h0;
      skid_pc       <= 32'h0;
      IFout_Valid   <= 1'b0;
      IFout_Inst    <= 32'h0;
      IFout_PC      <= 32'h0;
      IFout_PCplus4 <= 32'h0;
    end else if (IFin_PCSrc) begin
      // Redirect wins over stall and squashes everything this stage holds.
      pc_q        <= IFin_Btarg_or_Jtarg & ~32'h3;
      f2_valid    <= 1'b0;
      skid_valid  <= 1'b0;
      IFout_Valid <= 1'b0;
    end else if (IFin_Stall) begin
      f2_valid <= 1'b0;
      if (f2_valid) begin
        skid_valid <= 1'b1;
        skid_inst  <= IFin_Inst;
        skid_pc    <= f2_pc;
      end
    end else begin
      pc_q       <= pc_q + 32'd4;
      f2_valid   <= 1'b1;
      f2_pc      <= pc_q;
      skid_valid <= 1'b0;
      if (load_en) begin
        IFout_Valid   <= 1'b1;
        IFout_Inst    <= load_inst;
        IFout_PC      <= load_pc;
        IFout_PCplus4 <= load_pc + 32'd4;
      end else begin
        IFout_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// tb/tb_stage_if.sv - Directed bench for stage_if; memory echoes the fetch address as data
module tb_stage_if;

  logic        Clk;
  logic        Rst_n;
  logic        IFin_PCSrc;
  logic [31:0] IFin_Btarg_or_Jtarg;
  logic        IFin_Stall;
  logic [31:0] IFout_Iaddr;
  logic        IFout_Ireq;
  logic [31:0] IFin_Inst;
  logic [31:0] IFout_Inst;
  logic [31:0] IFout_PC;
  logic [31:0] IFout_PCplus4;
  logic        IFout_Valid;

  int checks;
  int failures;

  stage_if #(.RESET_PC(32'h0000_3000)) dut (
    .Clk                 (Clk),
    .Rst_n               (Rst_n),
    .IFin_PCSrc          (IFin_PCSrc),
    .IFin_Btarg_or_Jtarg (IFin_Btarg_or_Jtarg),
    .IFin_Stall          (IFin_Stall),
    .IFout_Iaddr         (IFout_Iaddr),
    .IFout_Ireq          (IFout_Ireq),
    .IFin_Inst           (IFin_Inst),
    .IFout_Inst          (IFout_Inst),
    .IFout_PC            (IFout_PC),
    .IFout_PCplus4       (IFout_PCplus4),
    .IFout_Valid         (IFout_Valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous-read memory: data for an accepted request appears next cycle, junk otherwise.
  always @(posedge Clk) IFin_Inst <= IFout_Ireq ? IFout_Iaddr : 32'hDEAD_BEEF;

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    step();
    step();
    checks++; if (IFout_Iaddr !== 32'h3000) begin failures++; $display("FAIL reset_iaddr actual=%h expected=%h", IFout_Iaddr, 32'h3000); end
    checks++; if (IFout_Ireq !== 1'b0) begin failures++; $display("FAIL reset_ireq actual=%b expected=0", IFout_Ireq); end
    checks++; if (IFout_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b expected=0", IFout_Valid); end
    checks++; if (IFout_Inst !== 32'h0) begin failures++; $display("FAIL reset_inst actual=%h expected=0", IFout_Inst); end
    checks++; if (IFout_PC !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h expected=0", IFout_PC); end
    checks++; if (IFout_PCplus4 !== 32'h0) begin failures++; $display("FAIL reset_pcplus4 actual=%h expected=0", IFout_PCplus4); end
  endtask

  task automatic test_stream;
    logic [31:0] e;
    Rst_n = 1'b1;
    #1;
    checks++; if (IFout_Ireq !== 1'b1) begin failures++; $display("FAIL stream_ireq actual=%b expected=1", IFout_Ireq); end
    step();
    checks++; if (IFout_Valid !== 1'b0) begin failures++; $display("FAIL stream_first_edge_valid actual=%b expected=0", IFout_Valid); end
    for (int i = 0; i < 3; i++) begin
      e = 32'h3000 + 32'(4 * i);
      step();
      checks++; if (IFout_Valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] actual=%b expected=1", i, IFout_Valid); end
      checks++; if (IFout_PC !== e) begin failures++; $display("FAIL stream_pc[%0d] actual=%h expected=%h", i, IFout_PC, e); end
      checks++; if (IFout_Inst !== e) begin failures++; $display("FAIL stream_inst[%0d] actual=%h expected=%h", i, IFout_Inst, e); end
      checks++; if (IFout_PCplus4 !== e + 32'd4) begin failures++; $display("FAIL stream_pcplus4[%0d] actual=%h expected=%h", i, IFout_PCplus4, e + 32'd4); end
    end
  endtask

  task automatic test_stall;
    IFin_Stall = 1'b1;
    #1;
    checks++; if (IFout_Ireq !== 1'b0) begin failures++; $display("FAIL stall_ireq actual=%b expected=0", IFout_Ireq); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (IFout_PC !== 32'h3008 || IFout_Valid !== 1'b1) begin failures++; $display("FAIL stall_hold[%0d] actual=%h/%b expected=00003008/1", i, IFout_PC, IFout_Valid); end
      checks++; if (IFout_Iaddr !== 32'h3010) begin failures++; $display("FAIL stall_iaddr[%0d] actual=%h expected=00003010", i, IFout_Iaddr); end
    end
    IFin_Stall = 1'b0;
    step();
    checks++; if (IFout_PC !== 32'h300C || IFout_Inst !== 32'h300C || IFout_Valid !== 1'b1) begin failures++; $display("FAIL stall_drain actual=%h/%h/%b expected=0000300c/0000300c/1", IFout_PC, IFout_Inst, IFout_Valid); end
    step();
    checks++; if (IFout_PC !== 32'h3010 || IFout_Inst !== 32'h3010 || IFout_Valid !== 1'b1) begin failures++; $display("FAIL stall_next actual=%h/%h/%b expected=00003010/00003010/1", IFout_PC, IFout_Inst, IFout_Valid); end
  endtask

  task automatic test_redirect;
    IFin_PCSrc = 1'b1;
    IFin_Btarg_or_Jtarg = 32'h4002;
    #1;
    checks++; if (IFout_Ireq !== 1'b0) begin failures++; $display("FAIL redir_ireq actual=%b expected=0", IFout_Ireq); end
    step();
    IFin_PCSrc = 1'b0;
    #1;
    checks++; if (IFout_Iaddr !== 32'h4000) begin failures++; $display("FAIL redir_iaddr actual=%h expected=00004000", IFout_Iaddr); end
    checks++; if (IFout_Valid !== 1'b0) begin failures++; $display("FAIL redir_bubble1 actual=%b expected=0", IFout_Valid); end
    step();
    checks++; if (IFout_Valid !== 1'b0) begin failures++; $display("FAIL redir_bubble2 actual=%b expected=0", IFout_Valid); end
    step();
    checks++; if (IFout_PC !== 32'h4000 || IFout_Inst !== 32'h4000 || IFout_Valid !== 1'b1) begin failures++; $display("FAIL redir_target actual=%h/%h/%b expected=00004000/00004000/1", IFout_PC, IFout_Inst, IFout_Valid); end
    checks++; if (IFout_PCplus4 !== 32'h4004) begin failures++; $display("FAIL redir_pcplus4 actual=%h expected=00004004", IFout_PCplus4); end
    step();
    checks++; if (IFout_PC !== 32'h4004 || IFout_Valid !== 1'b1) begin failures++; $display("FAIL redir_follow actual=%h/%b expected=00004004/1", IFout_PC, IFout_Valid); end
  endtask

  task automatic test_stall_redirect;
    IFin_Stall = 1'b1;
    step();
    checks++; if (IFout_PC !== 32'h4004 || IFout_Valid !== 1'b1) begin failures++; $display("FAIL sr_hold actual=%h/%b expected=00004004/1", IFout_PC, IFout_Valid); end
    IFin_PCSrc = 1'b1;
    IFin_Btarg_or_Jtarg = 32'h5000;
    step();
    IFin_PCSrc = 1'b0;
    #1;
    checks++; if (IFout_Iaddr !== 32'h5000 || IFout_Valid !== 1'b0 || IFout_Ireq !== 1'b0) begin failures++; $display("FAIL sr_redirect actual=%h/%b/%b expected=00005000/0/0", IFout_Iaddr, IFout_Valid, IFout_Ireq); end
    step();
    checks++; if (IFout_Valid !== 1'b0) begin failures++; $display("FAIL sr_skid_cleared actual=%b expected=0", IFout_Valid); end
    IFin_Stall = 1'b0;
    #1;
    checks++; if (IFout_Ireq !== 1'b1) begin failures++; $display("FAIL sr_release_ireq actual=%b expected=1", IFout_Ireq); end
    step();
    checks++; if (IFout_Valid !== 1'b0 || IFout_Iaddr !== 32'h5004) begin failures++; $display("FAIL sr_release actual=%b/%h expected=0/00005004", IFout_Valid, IFout_Iaddr); end
    step();
    checks++; if (IFout_PC !== 32'h5000 || IFout_Inst !== 32'h5000 || IFout_Valid !== 1'b1) begin failures++; $display("FAIL sr_target actual=%h/%h/%b expected=00005000/00005000/1", IFout_PC, IFout_Inst, IFout_Valid); end
  endtask

  task automatic test_reset_mid;
    Rst_n = 1'b0;
    #1;
    checks++; if (IFout_Valid !== 1'b0 || IFout_PC !== 32'h0 || IFout_Inst !== 32'h0 || IFout_PCplus4 !== 32'h0) begin failures++; $display("FAIL rmid_ifid actual=%b/%h/%h/%h expected=0/0/0/0", IFout_Valid, IFout_PC, IFout_Inst, IFout_PCplus4); end
    checks++; if (IFout_Iaddr !== 32'h3000 || IFout_Ireq !== 1'b0) begin failures++; $display("FAIL rmid_fetch actual=%h/%b expected=00003000/0", IFout_Iaddr, IFout_Ireq); end
    #1;
    Rst_n = 1'b1;
    step();
    checks++; if (IFout_Valid !== 1'b0 || IFout_Iaddr !== 32'h3004) begin failures++; $display("FAIL rmid_ignore actual=%b/%h expected=0/00003004", IFout_Valid, IFout_Iaddr); end
    step();
    checks++; if (IFout_PC !== 32'h3000 || IFout_Inst !== 32'h3000 || IFout_Valid !== 1'b1) begin failures++; $display("FAIL rmid_first actual=%h/%h/%b expected=00003000/00003000/1", IFout_PC, IFout_Inst, IFout_Valid); end
  endtask

  task automatic test_wrap;
    IFin_PCSrc = 1'b1;
    IFin_Btarg_or_Jtarg = 32'hFFFF_FFFF;
    step();
    IFin_PCSrc = 1'b0;
    #1;
    checks++; if (IFout_Iaddr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_target actual=%h expected=fffffffc", IFout_Iaddr); end
    step();
    checks++; if (IFout_Iaddr !== 32'h0) begin failures++; $display("FAIL wrap_iaddr actual=%h expected=00000000", IFout_Iaddr); end
    step();
    checks++; if (IFout_PC !== 32'hFFFF_FFFC || IFout_PCplus4 !== 32'h0 || IFout_Valid !== 1'b1) begin failures++; $display("FAIL wrap_ifid actual=%h/%h/%b expected=fffffffc/00000000/1", IFout_PC, IFout_PCplus4, IFout_Valid); end
    step();
    checks++; if (IFout_PC !== 32'h0 || IFout_Inst !== 32'h0 || IFout_PCplus4 !== 32'h4) begin failures++; $display("FAIL wrap_next actual=%h/%h/%h expected=0/0/4", IFout_PC, IFout_Inst, IFout_PCplus4); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    Rst_n = 1'b0;
    IFin_PCSrc = 1'b0;
    IFin_Btarg_or_Jtarg = 32'h0;
    IFin_Stall = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
